flr_rsp_sequencer: RTL and testbench

FLR_RSP_SEQUENCER -- requirements
Module: flr_rsp_sequencer

---
 rtl/flr_rsp_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_flr_rsp_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/flr_rsp_sequencer.sv
// Function-level-reset response sequencer. It serialises PF and VF FLR requests into
// function-reset handshakes and emits done/completion pulses once each function has quiesced.
module flr_rsp_sequencer #(
  parameter int VF_FIFO_DEPTH   = 4,
  parameter int RST_HOLD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_flr_pf_active,
  input  logic        i_flr_rcvd_vf,
  input  logic [2:0]  i_flr_rcvd_pf_num,
  input  logic [10:0] i_flr_rcvd_vf_num,
  output logic [7:0]  o_flr_pf_done,
  output logic        o_flr_completed_vf,
  output logic [2:0]  o_flr_completed_pf_num,
  output logic [10:0] o_flr_completed_vf_num,
  output logic        o_func_rst_req,
  output logic        o_func_rst_vf_active,
  output logic [2:0]  o_func_rst_pf_num,
  output logic [10:0] o_func_rst_vf_num,
  input  logic        i_func_rst_ack,
  output logic        o_vf_fifo_overflow
);

  localparam int AW   = (VF_FIFO_DEPTH > 1) ? $clog2(VF_FIFO_DEPTH) : 1;
  localparam int CNTW = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam logic [CNTW-1:0] HOLD_INIT = CNTW'(RST_HOLD_CYCLES - 1);
  localparam logic [AW:0]     FIFO_FULL = (AW + 1)'(VF_FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HOLD     = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         pf_in_q, pf_in_d;
  logic [7:0]         pending_q, pending_d;
  logic [13:0]        mem_q [VF_FIFO_DEPTH];
  logic [13:0]        mem_d [VF_FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic               overflow_q, overflow_d;
  logic               req_q, req_d;
  logic               vf_active_q, vf_active_d;
  logic [2:0]         pf_num_q, pf_num_d;
  logic [10:0]        vf_num_q, vf_num_d;
  logic [7:0]         pf_done_q, pf_done_d;
  logic               cmp_vf_q, cmp_vf_d;
  logic [2:0]         cmp_pf_q, cmp_pf_d;
  logic [10:0]        cmp_vfn_q, cmp_vfn_d;

  logic [7:0]         pf_rise_s, pending_clr_s;
  logic               pop_s, full_s, push_ok_s;
  logic [13:0]        head_s;

  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
      else      idx = idx;
    end
    return idx;
  endfunction

  assign o_flr_pf_done          = pf_done_q;
  assign o_flr_completed_vf     = cmp_vf_q;
  assign o_flr_completed_pf_num = cmp_pf_q;
  assign o_flr_completed_vf_num = cmp_vfn_q;
  assign o_func_rst_req         = req_q;
  assign o_func_rst_vf_active   = vf_active_q;
  assign o_func_rst_pf_num      = pf_num_q;
  assign o_func_rst_vf_num      = vf_num_q;
  assign o_vf_fifo_overflow     = overflow_q;

  // Next-state logic for edge detect, VF request FIFO and the service FSM.
  always_comb begin
    state_d       = state_q;
    pf_in_d       = i_flr_pf_active;
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    cnt_d         = cnt_q;
    overflow_d    = overflow_q;
    req_d         = req_q;
    vf_active_d   = vf_active_q;
    pf_num_d      = pf_num_q;
    vf_num_d      = vf_num_q;
    pf_done_d     = 8'd0;
    cmp_vf_d      = 1'b0;
    cmp_pf_d      = 3'd0;
    cmp_vfn_d     = 11'd0;
    pending_clr_s = 8'd0;

    pf_rise_s = i_flr_pf_active & ~pf_in_q;
    head_s    = mem_q[rd_ptr_q];
    full_s    = (count_q == FIFO_FULL);
    pop_s     = (state_q == S_IDLE) && (pending_q == 8'd0) && (count_q != '0);
    push_ok_s = i_flr_rcvd_vf && (!full_s || pop_s);

    if (push_ok_s) begin
      mem_d[wr_ptr_q] = {i_flr_rcvd_pf_num, i_flr_rcvd_vf_num};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end else if (i_flr_rcvd_vf) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end

    if (pop_s) rd_ptr_d = rd_ptr_q + 1'b1;
    else       rd_ptr_d = rd_ptr_q;

    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (pending_q != 8'd0) begin
          state_d     = S_HOLD;
          cnt_d       = HOLD_INIT;
          req_d       = 1'b1;
          vf_active_d = 1'b0;
          pf_num_d    = lowest_idx(pending_q);
          vf_num_d    = 11'd0;
        end else if (count_q != '0) begin
          state_d     = S_HOLD;
          cnt_d       = HOLD_INIT;
          req_d       = 1'b1;
          vf_active_d = 1'b1;
          pf_num_d    = head_s[13:11];
          vf_num_d    = head_s[10:0];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) state_d = S_WAIT_ACK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_WAIT_ACK: begin
        if (i_func_rst_ack) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          if (vf_active_q) begin
            cmp_vf_d  = 1'b1;
            cmp_pf_d  = pf_num_q;
            cmp_vfn_d = vf_num_q;
          end else begin
            pf_done_d = 8'd1 << pf_num_q;
          end
        end else begin
          state_d = S_WAIT_ACK;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        // An edge landing in this same cycle is absorbed by the service just finished.
        if (!vf_active_q) pending_clr_s = 8'd1 << pf_num_q;
        else              pending_clr_s = 8'd0;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase

    pending_d = (pending_q | pf_rise_s) & ~pending_clr_s;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pf_in_q     <= 8'd0;
      pending_q   <= 8'd0;
      for (int i = 0; i < VF_FIFO_DEPTH; i++) mem_q[i] <= 14'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cnt_q       <= '0;
      overflow_q  <= 1'b0;
      req_q       <= 1'b0;
      vf_active_q <= 1'b0;
      pf_num_q    <= 3'd0;
      vf_num_q    <= 11'd0;
      pf_done_q   <= 8'd0;
      cmp_vf_q    <= 1'b0;
      cmp_pf_q    <= 3'd0;
      cmp_vfn_q   <= 11'd0;
    end else begin
      state_q     <= state_d;
      pf_in_q     <= pf_in_d;
      pending_q   <= pending_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cnt_q       <= cnt_d;
      overflow_q  <= overflow_d;
      req_q       <= req_d;
      vf_active_q <= vf_active_d;
      pf_num_q    <= pf_num_d;
      vf_num_q    <= vf_num_d;
      pf_done_q   <= pf_done_d;
      cmp_vf_q    <= cmp_vf_d;
      cmp_pf_q    <= cmp_pf_d;
      cmp_vfn_q   <= cmp_vfn_d;
    end
  end

endmodule

// File: tb/tb_flr_rsp_sequencer.sv
// Directed bench for flr_rsp_sequencer: PF/VF service order, timing, FIFO overflow and reset abort.
module tb_flr_rsp_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  flr_pf_active;
  logic        flr_rcvd_vf;
  logic [2:0]  flr_rcvd_pf_num;
  logic [10:0] flr_rcvd_vf_num;
  logic [7:0]  flr_pf_done;
  logic        flr_completed_vf;
  logic [2:0]  flr_completed_pf_num;
  logic [10:0] flr_completed_vf_num;
  logic        func_rst_req;
  logic        func_rst_vf_active;
  logic [2:0]  func_rst_pf_num;
  logic [10:0] func_rst_vf_num;
  logic        func_rst_ack;
  logic        vf_fifo_overflow;
  logic [39:0] all_out;

  int checks = 0;
  int errors = 0;
  int req_cycles = 0;

  always #5 clk = ~clk;

  flr_rsp_sequencer #(.VF_FIFO_DEPTH(4), .RST_HOLD_CYCLES(16)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .i_flr_pf_active        (flr_pf_active),
    .i_flr_rcvd_vf          (flr_rcvd_vf),
    .i_flr_rcvd_pf_num      (flr_rcvd_pf_num),
    .i_flr_rcvd_vf_num      (flr_rcvd_vf_num),
    .o_flr_pf_done          (flr_pf_done),
    .o_flr_completed_vf     (flr_completed_vf),
    .o_flr_completed_pf_num (flr_completed_pf_num),
    .o_flr_completed_vf_num (flr_completed_vf_num),
    .o_func_rst_req         (func_rst_req),
    .o_func_rst_vf_active   (func_rst_vf_active),
    .o_func_rst_pf_num      (func_rst_pf_num),
    .o_func_rst_vf_num      (func_rst_vf_num),
    .i_func_rst_ack         (func_rst_ack),
    .o_vf_fifo_overflow     (vf_fifo_overflow)
  );

  assign all_out = {flr_pf_done, flr_completed_vf, flr_completed_pf_num, flr_completed_vf_num,
                    func_rst_req, func_rst_vf_active, func_rst_pf_num, func_rst_vf_num,
                    vf_fifo_overflow};

  always @(negedge clk) if (func_rst_req === 1'b1) req_cycles <= req_cycles + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic vf_pulse(input logic [2:0] pf, input logic [10:0] vf);
    flr_rcvd_vf     = 1'b1;
    flr_rcvd_pf_num = pf;
    flr_rcvd_vf_num = vf;
    @(negedge clk);
    flr_rcvd_vf     = 1'b0;
  endtask

  // Advances to the next negedge showing a done/completed pulse, or gives up after budget.
  task automatic wait_done(input int budget, output logic got, output int cycles);
    got    = 1'b0;
    cycles = 0;
    while (!got && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (flr_pf_done !== 8'd0 || flr_completed_vf === 1'b1) got = 1'b1;
    end
  endtask

  task automatic expect_vf(input string tag, input logic [2:0] pf, input logic [10:0] vf);
    logic got;
    int   cyc;
    wait_done(100, got, cyc);
    chk({tag, "_seen"}, {63'd0, got}, 64'd1);
    chk({tag, "_nums"}, {48'd0, flr_pf_done, flr_completed_vf, pf_pad(flr_completed_pf_num),
                         flr_completed_vf_num}, {48'd0, 8'd0, 1'b1, pf_pad(pf), vf});
  endtask

  function automatic logic [3:0] pf_pad(input logic [2:0] p);
    return {1'b0, p};
  endfunction

  task automatic expect_pf(input string tag, input logic [7:0] mask, input int exp_cyc);
    logic got;
    int   cyc;
    wait_done(100, got, cyc);
    chk({tag, "_seen"}, {63'd0, got}, 64'd1);
    chk({tag, "_mask"}, {55'd0, flr_completed_vf, flr_pf_done}, {55'd0, 1'b0, mask});
    if (exp_cyc > 0) chk({tag, "_latency"}, 64'(cyc), 64'(exp_cyc));
    else             chk({tag, "_req_low"}, {63'd0, func_rst_req}, 64'd0);
  endtask

  initial begin
    logic got;
    int   cyc;
    int   base;

    rst_n           = 1'b0;
    flr_pf_active   = 8'd0;
    flr_rcvd_vf     = 1'b0;
    flr_rcvd_pf_num = 3'd0;
    flr_rcvd_vf_num = 11'd0;
    func_rst_ack    = 1'b1;
    tick(3);
    chk("reset_outputs", {24'd0, all_out}, 64'd0);
    rst_n = 1'b1;
    tick(2);
    chk("idle_outputs", {24'd0, all_out}, 64'd0);

    // PF2 with ack tied high: 1 edge-register cycle + 18 service cycles, 17 cycles of req.
    base = req_cycles;
    flr_pf_active = 8'h04;
    wait_done(100, got, cyc);
    chk("pf2_seen", {63'd0, got}, 64'd1);
    chk("pf2_mask", {56'd0, flr_pf_done}, 64'h04);
    chk("pf2_latency", 64'(cyc), 64'd19);
    chk("pf2_target", {48'd0, func_rst_vf_active, pf_pad(func_rst_pf_num), func_rst_vf_num},
        {48'd0, 1'b0, 4'd2, 11'd0});
    tick(1);
    chk("pf2_pulse_one_cycle", {56'd0, flr_pf_done}, 64'd0);
    chk("pf2_req_cycles", 64'(req_cycles - base), 64'd17);
    flr_pf_active = 8'h00;
    tick(3);

    // Two VF requests served in arrival order.
    vf_pulse(3'd0, 11'd5);
    vf_pulse(3'd1, 11'd2047);
    expect_vf("vf5", 3'd0, 11'd5);
    expect_vf("vf2047", 3'd1, 11'd2047);
    chk("vf_no_overflow", {63'd0, vf_fifo_overflow}, 64'd0);
    tick(3);

    // PFs arriving during a VF service queue behind it, lowest index first, one IDLE gap.
    vf_pulse(3'd0, 11'd3);
    tick(5);
    flr_pf_active = 8'h42;
    expect_vf("order_vf3", 3'd0, 11'd3);
    expect_pf("order_pf1", 8'h02, 0);
    expect_pf("order_pf6", 8'h40, 19);
    flr_pf_active = 8'h00;
    tick(3);

    // Blocked ack: six requests against a 4-deep FIFO, then a push accepted while full on a pop.
    func_rst_ack = 1'b0;
    vf_pulse(3'd0, 11'd10);
    tick(25);
    chk("blocked_req_high", {63'd0, func_rst_req}, 64'd1);
    for (int k = 1; k <= 6; k++) vf_pulse(3'd1, 11'(k));
    chk("overflow_set", {63'd0, vf_fifo_overflow}, 64'd1);
    func_rst_ack = 1'b1;
    expect_vf("ovf_vf10", 3'd0, 11'd10);
    tick(1);
    vf_pulse(3'd1, 11'd7);
    expect_vf("ovf_vf1", 3'd1, 11'd1);
    expect_vf("ovf_vf2", 3'd1, 11'd2);
    expect_vf("ovf_vf3", 3'd1, 11'd3);
    expect_vf("ovf_vf4", 3'd1, 11'd4);
    expect_vf("ovf_vf7", 3'd1, 11'd7);
    wait_done(60, got, cyc);
    chk("ovf_no_extra", {63'd0, got}, 64'd0);
    chk("overflow_sticky", {63'd0, vf_fifo_overflow}, 64'd1);

    // Reset during WAIT_ACK of PF3 aborts; PF3 held high is serviced again after release.
    func_rst_ack  = 1'b0;
    flr_pf_active = 8'h08;
    tick(25);
    chk("pf3_waiting", {60'd0, func_rst_req, func_rst_pf_num}, {60'd0, 1'b1, 3'd3});
    rst_n = 1'b0;
    tick(1);
    chk("abort_outputs", {24'd0, all_out}, 64'd0);
    tick(2);
    chk("abort_still_zero", {24'd0, all_out}, 64'd0);
    func_rst_ack = 1'b1;
    rst_n = 1'b1;
    expect_pf("pf3_reserv", 8'h08, 19);
    chk("reset_cleared_overflow", {63'd0, vf_fifo_overflow}, 64'd0);
    flr_pf_active = 8'h00;
    tick(3);

    // Ack high during HOLD is ignored; completion follows one cycle after ack returns.
    func_rst_ack  = 1'b1;
    flr_pf_active = 8'h01;
    tick(5);
    func_rst_ack = 1'b0;
    tick(20);
    chk("ack_wait_state", {55'd0, func_rst_req, flr_pf_done}, {55'd0, 1'b1, 8'd0});
    func_rst_ack = 1'b1;
    tick(1);
    chk("ack_done_pulse", {55'd0, func_rst_req, flr_pf_done}, {55'd0, 1'b0, 8'h01});
    flr_pf_active = 8'h00;
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
